// File: rtl/parking_sensor_fsm.sv
// parking_sensor_fsm: gate sensor front end for the occupancy counter.
// Synchronizes and debounces the two photosensor lines, then tracks the
// car-passage sequence and emits one-cycle inc/dec/err pulses.
`timescale 1ns/1ps
module parking_sensor_fsm #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic inc,
  output logic dec,
  output logic err,
  output logic busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3, ERR
  } state_t;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             sab, fab, cand;
  logic [CW-1:0]          cnt, cnt_step;
  state_t                 state, state_next;
  logic                   inc_d, dec_d, err_d;

  // Synchronizer chains for the raw sensor lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], b};
    end
  end

  assign sab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Count for the sample being taken: continue the current candidate or restart at 1
  always_comb begin
    if (cnt != '0 && sab == cand)
      cnt_step = (cnt == CMAX) ? CMAX : cnt + 1'b1;
    else
      cnt_step = CW'(1);
  end

  // Debounce: fab follows sab only after STABLE_CYCLES identical samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fab  <= '0;
      cand <= '0;
      cnt  <= '0;
    end else if (sab == fab) begin
      cnt <= '0;
    end else if (cnt_step == CMAX) begin
      fab <= sab;
      cnt <= '0;
    end else begin
      cand <= sab;
      cnt  <= cnt_step;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic on the filtered sensor pair; unlisted cases hold
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: case (fab)
              2'b10: state_next = ENT1;
              2'b01: state_next = EXT1;
              2'b11: state_next = ERR;
              default: ;
            endcase
      ENT1: case (fab)
              2'b11: state_next = ENT2;
              2'b00: state_next = IDLE;
              2'b01: state_next = ERR;
              default: ;
            endcase
      ENT2: case (fab)
              2'b01: state_next = ENT3;
              2'b10: state_next = ENT1;
              2'b00: state_next = ERR;
              default: ;
            endcase
      ENT3: case (fab)
              2'b00: state_next = IDLE;
              2'b11: state_next = ENT2;
              2'b10: state_next = ERR;
              default: ;
            endcase
      EXT1: case (fab)
              2'b11: state_next = EXT2;
              2'b00: state_next = IDLE;
              2'b10: state_next = ERR;
              default: ;
            endcase
      EXT2: case (fab)
              2'b10: state_next = EXT3;
              2'b01: state_next = EXT1;
              2'b00: state_next = ERR;
              default: ;
            endcase
      EXT3: case (fab)
              2'b00: state_next = IDLE;
              2'b11: state_next = EXT2;
              2'b01: state_next = ERR;
              default: ;
            endcase
      ERR:  if (fab == 2'b00) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Event decode for the registered pulses, plus busy from the current state
  always_comb begin
    inc_d = (state == ENT3) && (fab == 2'b00);
    dec_d = (state == EXT3) && (fab == 2'b00);
    err_d = (state_next == ERR) && (state != ERR);
    busy  = (state != IDLE);
  end

  // Pulse registers, aligned with the state change that caused them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc <= 1'b0;
      dec <= 1'b0;
      err <= 1'b0;
    end else begin
      inc <= inc_d;
      dec <= dec_d;
      err <= err_d;
    end
  end

endmodule

// File: tb/tb_parking_sensor_fsm.sv
// tb_parking_sensor_fsm: directed scenarios with a pulse scoreboard.
`timescale 1ns/1ps
module tb_parking_sensor_fsm;

  logic clk = 1'b0;
  logic reset, a, b;
  logic inc, dec, err, busy;

  localparam int K_INC = 1;
  localparam int K_DEC = 2;
  localparam int K_ERR = 4;
  localparam int LAT   = 7;

  typedef struct { int kind; int cyc; } ev_t;
  ev_t exp_q[$];

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;
  int n_inc    = 0;
  int n_dec    = 0;

  parking_sensor_fsm #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .inc(inc), .dec(dec), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // One clock: sample after the edge and reconcile pulses with the scoreboard
  task automatic tick();
    int obs;
    ev_t e;
    @(posedge clk);
    cyc++;
    #1;
    obs = int'({err, dec, inc});
    chk("inc_dec_exclusive", int'(inc & dec), 0);
    if (inc) n_inc++;
    if (dec) n_dec++;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missed_pulse", 0, e.kind);
    end
    if (obs != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", obs, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", obs, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  endtask

  // Drive a sensor pair, hold it 10 cycles, check busy on both sides of its settle edge
  task automatic step(input logic [1:0] ab, input logic bb, input logic ba, input int kind);
    ev_t e;
    a = ab[1];
    b = ab[0];
    if (kind != 0) begin
      e.kind = kind;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
    end
    repeat (LAT - 1) tick();
    chk("busy_before", int'(busy), int'(bb));
    tick();
    chk("busy_after", int'(busy), int'(ba));
    repeat (3) tick();
  endtask

  task automatic entry();
    step(2'b10, 0, 1, 0);
    step(2'b11, 1, 1, 0);
    step(2'b01, 1, 1, 0);
    step(2'b00, 1, 0, K_INC);
  endtask

  task automatic exit_seq();
    step(2'b01, 0, 1, 0);
    step(2'b11, 1, 1, 0);
    step(2'b10, 1, 1, 0);
    step(2'b00, 1, 0, K_DEC);
  endtask

  initial begin
    int ci, cd;
    reset = 1'b0;
    a = 1'b0;
    b = 1'b0;
    repeat (2) tick();
    chk("rst_inc", int'(inc), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (3) tick();

    // 1: entry
    ci = n_inc; cd = n_dec;
    entry();
    chk("t1_inc_count", n_inc - ci, 1);
    chk("t1_dec_count", n_dec - cd, 0);

    // 2: exit
    ci = n_inc; cd = n_dec;
    exit_seq();
    chk("t2_dec_count", n_dec - cd, 1);
    chk("t2_inc_count", n_inc - ci, 0);

    // 3: abort, then back-out and re-advance
    ci = n_inc;
    step(2'b10, 0, 1, 0);
    step(2'b00, 1, 0, 0);
    chk("t3_abort_inc", n_inc - ci, 0);
    step(2'b10, 0, 1, 0);
    step(2'b11, 1, 1, 0);
    step(2'b10, 1, 1, 0);
    step(2'b11, 1, 1, 0);
    step(2'b01, 1, 1, 0);
    step(2'b00, 1, 0, K_INC);
    chk("t3_backout_inc", n_inc - ci, 1);

    // 4: illegal jump into ERR, recovery, then a short glitch on a
    step(2'b11, 0, 1, K_ERR);
    step(2'b10, 1, 1, 0);
    step(2'b00, 1, 0, 0);
    a = 1'b1;
    repeat (2) tick();
    a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t4_glitch_busy", int'(busy), 0);
    end

    // 5: reset while in ENT3, released with sensors clear
    ci = n_inc;
    step(2'b10, 0, 1, 0);
    step(2'b11, 1, 1, 0);
    step(2'b01, 1, 1, 0);
    reset = 1'b0;
    #1;
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_outs", int'({err, dec, inc}), 0);
    tick();
    reset = 1'b1;
    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_idle_busy", int'(busy), 0);
    end
    chk("t5_no_inc", n_inc - ci, 0);
    entry();
    chk("t5_entry_inc", n_inc - ci, 1);

    // 6: back-to-back traffic
    ci = n_inc; cd = n_dec;
    repeat (3) entry();
    repeat (2) exit_seq();
    chk("t6_inc_count", n_inc - ci, 3);
    chk("t6_dec_count", n_dec - cd, 2);

    repeat (10) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
